// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared types and constants for the four-digit seven-segment scanner.
//   SEG_LUT     : hex nibble -> active-low segments, bit order gfedcba
//   SEG_BLANK   : all segments off
//   scan_state_t: scan FSM states (BLANK, DRIVE)
//   disp_word_t : one display word {value, digit_en, dp} used by the
//                 pending and shadow registers
// Helper functions: seg_decode (table lookup), lzs_mask (leading-zero
// suppression mask, used only when SEVEN_SEG_LZS_EN is defined).
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  // This board has exactly four digits; the index width follows from that.
  localparam int DIGITS = 4;
  localparam int IDX_W  = 2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, gfedcba. Index is the hex nibble.
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
  } disp_word_t;

  // Blank-equivalent display word: nothing lights until the first load.
  localparam disp_word_t DISP_RESET = '{value: 16'h0000, digit_en: 4'h0, dp: 4'h0};

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

  // Digits at or below the most-significant nonzero nibble may light.
  // Digit 0 is always allowed so that a value of zero still shows "0".
  function automatic logic [3:0] lzs_mask(input logic [15:0] v);
    logic [3:0] m;
    if (v[15:12] != 4'h0) begin
      m = 4'b1111;
    end else if (v[11:8] != 4'h0) begin
      m = 4'b0111;
    end else if (v[7:4] != 4'h0) begin
      m = 4'b0011;
    end else begin
      m = 4'b0001;
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Slot counter and BLANK/DRIVE scan FSM for the seven-segment scanner.
// Each digit slot is REFRESH_DIV cycles: BLANK_CYC cycles blank, then the
// rest driving. The outputs describe the state that takes effect on the
// coming clock edge, so the parent's registered outputs line up exactly
// with the slot timing instead of lagging it by one cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   idx        : digit index valid after the coming edge
//   drive      : 1 when the FSM will be in DRIVE after the coming edge
//   boundary   : 1 during the cycle whose closing edge ends the DRIVE slot
//                of the last digit (the frame boundary edge)
// -----------------------------------------------------------------------------
module scan_timer
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 2_000,
  parameter int NUM_DIGITS  = DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx,
  output logic             drive,
  output logic             boundary
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t      state_r;
  scan_state_t      state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_s;
  logic             boundary_s;

  // State, slot counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BLANK;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state logic. The counter runs across the whole slot; it only
  // restarts when a DRIVE phase ends, which is also when the index advances.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + CNT_W'(1);
    idx_s      = idx_r;
    boundary_s = 1'b0;
    case (state_r)
      BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = DRIVE;
        end else begin
          state_s = BLANK;
        end
      end
      DRIVE: begin
        if (cnt_r == SLOT_LAST) begin
          state_s = BLANK;
          cnt_s   = {CNT_W{1'b0}};
          if (idx_r == IDX_LAST) begin
            idx_s      = {IDX_W{1'b0}};
            boundary_s = 1'b1;
          end else begin
            idx_s      = idx_r + IDX_W'(1);
            boundary_s = 1'b0;
          end
        end else begin
          state_s = DRIVE;
        end
      end
      default: begin
        state_s = BLANK;
        cnt_s   = {CNT_W{1'b0}};
        idx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  assign idx      = idx_s;
  assign drive    = (state_s == DRIVE);
  assign boundary = boundary_s;

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexed controller for a 4-digit common-anode seven-segment
// display. A load strobe captures {value, digit_en, dp} into a pending
// register; the pending word moves into the shadow (displayed) register only
// at a frame boundary, so one frame never mixes old and new data. A load on
// the boundary edge itself goes straight into the shadow register.
// Optional build macro:
//   SEVEN_SEG_LZS_EN : leading-zero suppression (digits above the
//                      most-significant nonzero nibble stay dark)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   value[15:0] : hex value, nibble i -> digit i, digit 0 rightmost
//   digit_en[3:0], dp[3:0] : per-digit enable / decimal point (1 = lit)
//   load        : single-cycle capture strobe
//   seg[6:0]    : active-low segments gfedcba (registered)
//   dp_n        : active-low decimal point (registered)
//   an[3:0]     : active-low anodes, one-hot-low while driving (registered)
//   frame_done  : one-cycle pulse after each frame boundary (registered)
// -----------------------------------------------------------------------------
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = DIGITS,
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 2_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        frame_done
);

  disp_word_t       incoming_s;
  disp_word_t       pending_r;
  disp_word_t       shadow_r;
  logic             pending_valid_r;

  logic [IDX_W-1:0] idx_s;
  logic             drive_s;
  logic             boundary_s;

  logic [3:0]       lit_mask_s;
  logic [3:0]       nibble_s;
  logic [3:0]       an_s;
  logic [6:0]       seg_s;
  logic             dp_n_s;

  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_n_r;
  logic             frame_done_r;

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .NUM_DIGITS  (NUM_DIGITS)
  ) u_scan_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx_s),
    .drive    (drive_s),
    .boundary (boundary_s)
  );

  // Pack the load inputs into one display word.
  always_comb begin
    incoming_s          = DISP_RESET;
    incoming_s.value    = value;
    incoming_s.digit_en = digit_en;
    incoming_s.dp       = dp;
  end

  // Pending/shadow double buffer. At the boundary a coincident load wins over
  // any older pending word and pending_valid always ends cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r       <= DISP_RESET;
      shadow_r        <= DISP_RESET;
      pending_valid_r <= 1'b0;
    end else if (boundary_s) begin
      if (load) begin
        pending_r <= incoming_s;
        shadow_r  <= incoming_s;
      end else if (pending_valid_r) begin
        shadow_r  <= pending_r;
      end
      pending_valid_r <= 1'b0;
    end else if (load) begin
      pending_r       <= incoming_s;
      pending_valid_r <= 1'b1;
    end
  end

  // Which digits may light this frame.
`ifdef SEVEN_SEG_LZS_EN
  always_comb begin
    lit_mask_s = shadow_r.digit_en & lzs_mask(shadow_r.value);
  end
`else
  always_comb begin
    lit_mask_s = shadow_r.digit_en;
  end
`endif

  // Next output values. Shadow is only read while driving, and at least one
  // blank cycle follows every boundary, so a shadow swap is never visible
  // mid-slot.
  always_comb begin
    an_s     = 4'b1111;
    seg_s    = SEG_BLANK;
    dp_n_s   = 1'b1;
    nibble_s = shadow_r.value[{idx_s, 2'b00} +: 4];
    if (drive_s && lit_mask_s[idx_s]) begin
      an_s   = ~(4'b0001 << idx_s);
      seg_s  = seg_decode(nibble_s);
      dp_n_s = ~shadow_r.dp[idx_s];
    end else begin
      an_s   = 4'b1111;
      seg_s  = SEG_BLANK;
      dp_n_s = 1'b1;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r         <= 4'b1111;
      seg_r        <= SEG_BLANK;
      dp_n_r       <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_s;
      seg_r        <= seg_s;
      dp_n_r       <= dp_n_s;
      frame_done_r <= boundary_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp_n       = dp_n_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
// Directed self-checking bench for seven_seg_scanner with REFRESH_DIV=8 and
// BLANK_CYC=2 (32-cycle frames). Outputs are sampled 1 time unit after each
// rising edge. "pos" is the cycle position within a frame, 0..31, where pos 0
// is the cycle in which frame_done is high; digit d's slot is pos 8d..8d+7
// and its anode is driven from pos 8d+2.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic        load;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // One captured frame.
  logic [3:0] cap_an  [32];
  logic [6:0] cap_seg [32];
  logic       cap_dpn [32];
  logic       cap_fd  [32];

  // Hand-written expectations per digit for the frame under test.
  logic [3:0] xa [4];
  logic [6:0] xs [4];
  logic       xd [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dpn;

  seven_seg_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .digit_en   (digit_en),
    .dp         (dp),
    .load       (load),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d);
    value    = v;
    digit_en = en;
    dp       = d;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load     = 1'b0;
  endtask

  // Advance to the next frame_done cycle (pos 0), bounded.
  task automatic wait_frame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_wait: frame_done not seen within 40 cycles, required a pulse", tag);
    end
  endtask

  // Record pos 0 (current cycle) through pos 31.
  task automatic capture_frame();
    for (int k = 0; k < 32; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      cap_an[k]  = an;
      cap_seg[k] = seg;
      cap_dpn[k] = dp_n;
      cap_fd[k]  = frame_done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; value = 16'h0000; digit_en = 4'h0; dp = 4'h0;
    #23;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp_n !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got an=%b seg=%b dp_n=%b fd=%b, want 1111 1111111 1 0", an, seg, dp_n, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First frame boundary is the 32nd edge after release.
    begin
      int first;
      first = 0;
      for (int n = 1; n <= 40 && first == 0; n++) begin
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) first = n;
      end
      checks++;
      if (first != 32) begin
        errors++;
        $display("FAIL reset_first_frame: frame_done after %0d edges, want 32", first);
      end
    end
    // Three frames with no load: dark, frame_done only at pos 0.
    for (int f = 0; f < 3; f++) begin
      if (f != 0) wait_frame("reset_dark");
      capture_frame();
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (cap_an[k] !== 4'b1111 || cap_seg[k] !== 7'b1111111 || cap_dpn[k] !== 1'b1 || cap_fd[k] !== (k == 0)) begin
          errors++;
          $display("FAIL reset_dark f=%0d pos=%0d: got an=%b seg=%b dp_n=%b fd=%b, want an=1111 seg=1111111 dp_n=1 fd=%b",
                   f, k, cap_an[k], cap_seg[k], cap_dpn[k], cap_fd[k], k == 0);
        end
      end
    end
  endtask

  task automatic test_basic();
    wait_frame("basic");
    step(3);
    do_load(16'h1234, 4'hF, 4'h0);
    wait_frame("basic");
    capture_frame();
    xa = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    xs = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    xd = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 32; k++) begin
      exp_an  = (k % 8 < 2) ? 4'b1111 : xa[k / 8];
      exp_seg = (exp_an == 4'b1111) ? 7'b1111111 : xs[k / 8];
      exp_dpn = (exp_an == 4'b1111) ? 1'b1 : xd[k / 8];
      checks++;
      if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg || cap_dpn[k] !== exp_dpn || cap_fd[k] !== (k == 0)) begin
        errors++;
        $display("FAIL basic_1234 pos=%0d: got an=%b seg=%b dp_n=%b fd=%b, want an=%b seg=%b dp_n=%b fd=%b",
                 k, cap_an[k], cap_seg[k], cap_dpn[k], cap_fd[k], exp_an, exp_seg, exp_dpn, k == 0);
      end
    end
  endtask

  task automatic test_midframe_load();
    wait_frame("midframe");
    step(10);
    checks++;
    if (an !== 4'b1101 || seg !== 7'b0110000) begin
      errors++;
      $display("FAIL midframe_pre pos=10: got an=%b seg=%b, want an=1101 seg=0110000", an, seg);
    end
    do_load(16'hABCD, 4'hF, 4'h0);
    step(9);
    checks++;
    if (an !== 4'b1011 || seg !== 7'b0100100) begin
      errors++;
      $display("FAIL midframe_old_d2 pos=20: got an=%b seg=%b, want an=1011 seg=0100100", an, seg);
    end
    step(8);
    checks++;
    if (an !== 4'b0111 || seg !== 7'b1111001) begin
      errors++;
      $display("FAIL midframe_old_d3 pos=28: got an=%b seg=%b, want an=0111 seg=1111001", an, seg);
    end
    step(4);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL midframe_swap_fd: got frame_done=%b, want 1", frame_done);
    end
    capture_frame();
    xa = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    xs = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
    xd = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 32; k++) begin
      exp_an  = (k % 8 < 2) ? 4'b1111 : xa[k / 8];
      exp_seg = (exp_an == 4'b1111) ? 7'b1111111 : xs[k / 8];
      exp_dpn = (exp_an == 4'b1111) ? 1'b1 : xd[k / 8];
      checks++;
      if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg || cap_dpn[k] !== exp_dpn || cap_fd[k] !== (k == 0)) begin
        errors++;
        $display("FAIL midframe_abcd pos=%0d: got an=%b seg=%b dp_n=%b fd=%b, want an=%b seg=%b dp_n=%b fd=%b",
                 k, cap_an[k], cap_seg[k], cap_dpn[k], cap_fd[k], exp_an, exp_seg, exp_dpn, k == 0);
      end
    end
  endtask

  task automatic test_last_wins();
    wait_frame("last_wins");
    step(4);
    do_load(16'h0001, 4'hF, 4'h0);
    step(9);
    do_load(16'h00EF, 4'hF, 4'h0);
    wait_frame("last_wins");
    capture_frame();
`ifdef SEVEN_SEG_LZS_EN
    xa = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
    xa = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
    xs = '{7'b0001110, 7'b0000110, 7'b1000000, 7'b1000000};
    xd = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 32; k++) begin
      exp_an  = (k % 8 < 2) ? 4'b1111 : xa[k / 8];
      exp_seg = (exp_an == 4'b1111) ? 7'b1111111 : xs[k / 8];
      exp_dpn = (exp_an == 4'b1111) ? 1'b1 : xd[k / 8];
      checks++;
      if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg || cap_dpn[k] !== exp_dpn || cap_fd[k] !== (k == 0)) begin
        errors++;
        $display("FAIL last_wins_00ef pos=%0d: got an=%b seg=%b dp_n=%b fd=%b, want an=%b seg=%b dp_n=%b fd=%b",
                 k, cap_an[k], cap_seg[k], cap_dpn[k], cap_fd[k], exp_an, exp_seg, exp_dpn, k == 0);
      end
    end
  endtask

  task automatic test_boundary_load();
    wait_frame("boundary");
    step(19);
    do_load(16'h1111, 4'hF, 4'h0);
    step(11);
    // pos 31: the next edge is the frame boundary.
    do_load(16'h5678, 4'hF, 4'h0);
    capture_frame();
    xa = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    xs = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
    xd = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 32; k++) begin
      exp_an  = (k % 8 < 2) ? 4'b1111 : xa[k / 8];
      exp_seg = (exp_an == 4'b1111) ? 7'b1111111 : xs[k / 8];
      exp_dpn = (exp_an == 4'b1111) ? 1'b1 : xd[k / 8];
      checks++;
      if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg || cap_dpn[k] !== exp_dpn || cap_fd[k] !== (k == 0)) begin
        errors++;
        $display("FAIL boundary_5678 pos=%0d: got an=%b seg=%b dp_n=%b fd=%b, want an=%b seg=%b dp_n=%b fd=%b",
                 k, cap_an[k], cap_seg[k], cap_dpn[k], cap_fd[k], exp_an, exp_seg, exp_dpn, k == 0);
      end
    end
  endtask

  task automatic test_enable_dp();
    wait_frame("enable_dp");
    step(3);
    do_load(16'h8888, 4'b0101, 4'b0100);
    wait_frame("enable_dp");
    capture_frame();
    xa = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
    xs = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    xd = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 32; k++) begin
      exp_an  = (k % 8 < 2) ? 4'b1111 : xa[k / 8];
      exp_seg = (exp_an == 4'b1111) ? 7'b1111111 : xs[k / 8];
      exp_dpn = (exp_an == 4'b1111) ? 1'b1 : xd[k / 8];
      checks++;
      if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg || cap_dpn[k] !== exp_dpn || cap_fd[k] !== (k == 0)) begin
        errors++;
        $display("FAIL enable_dp pos=%0d: got an=%b seg=%b dp_n=%b fd=%b, want an=%b seg=%b dp_n=%b fd=%b",
                 k, cap_an[k], cap_seg[k], cap_dpn[k], cap_fd[k], exp_an, exp_seg, exp_dpn, k == 0);
      end
    end
  endtask

  task automatic test_reset_midscan();
    int first;
    wait_frame("rst_mid");
    step(20);
    checks++;
    if (an !== 4'b1011 || dp_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre pos=20: got an=%b dp_n=%b, want an=1011 dp_n=0", an, dp_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp_n !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got an=%b seg=%b dp_n=%b fd=%b, want 1111 1111111 1 0", an, seg, dp_n, frame_done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) first = n;
    end
    checks++;
    if (first != 32) begin
      errors++;
      $display("FAIL rst_mid_first_frame: frame_done after %0d edges, want 32", first);
    end
    capture_frame();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (cap_an[k] !== 4'b1111 || cap_seg[k] !== 7'b1111111 || cap_dpn[k] !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_dark pos=%0d: got an=%b seg=%b dp_n=%b, want an=1111 seg=1111111 dp_n=1",
                 k, cap_an[k], cap_seg[k], cap_dpn[k]);
      end
    end
    wait_frame("rst_mid");
    step(3);
    do_load(16'h1234, 4'hF, 4'h0);
    wait_frame("rst_mid");
    step(1);
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL rst_mid_relit_blank pos=1: got an=%b, want 1111", an);
    end
    step(1);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b0011001) begin
      errors++;
      $display("FAIL rst_mid_relit pos=2: got an=%b seg=%b, want an=1110 seg=0011001", an, seg);
    end
  endtask

`ifdef SEVEN_SEG_LZS_EN
  task automatic test_lzs();
    wait_frame("lzs");
    step(3);
    do_load(16'h0042, 4'hF, 4'h0);
    wait_frame("lzs");
    capture_frame();
    xa = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    xs = '{7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000};
    xd = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 32; k++) begin
      exp_an  = (k % 8 < 2) ? 4'b1111 : xa[k / 8];
      exp_seg = (exp_an == 4'b1111) ? 7'b1111111 : xs[k / 8];
      checks++;
      if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg) begin
        errors++;
        $display("FAIL lzs_0042 pos=%0d: got an=%b seg=%b, want an=%b seg=%b", k, cap_an[k], cap_seg[k], exp_an, exp_seg);
      end
    end
    wait_frame("lzs");
    step(3);
    do_load(16'h0000, 4'hF, 4'h0);
    wait_frame("lzs");
    capture_frame();
    xa = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    xs = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    for (int k = 0; k < 32; k++) begin
      exp_an  = (k % 8 < 2) ? 4'b1111 : xa[k / 8];
      exp_seg = (exp_an == 4'b1111) ? 7'b1111111 : xs[k / 8];
      checks++;
      if (cap_an[k] !== exp_an || cap_seg[k] !== exp_seg) begin
        errors++;
        $display("FAIL lzs_0000 pos=%0d: got an=%b seg=%b, want an=%b seg=%b", k, cap_an[k], cap_seg[k], exp_an, exp_seg);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_midframe_load();
    test_last_wins();
    test_boundary_load();
    test_enable_dp();
    test_reset_midscan();
`ifdef SEVEN_SEG_LZS_EN
    test_lzs();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
